// File: rtl/rgb_pwm_driver.sv
// Three-channel 8-bit PWM LED driver with double-buffered colour updates applied
// only at period boundaries, plus a run/drain controller for clean stops.
module rgb_pwm_driver #(
   parameter int PRESCALE = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [23:0] rgb,
   input  logic        rgb_valid,
   output logic        led_r,
   output logic        led_g,
   output logic        led_b,
   output logic        period_done,
   output logic        update_pending
);

   localparam int                PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PRE_W-1:0]  PRE_MAX = PRE_W'(PRESCALE - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [PRE_W-1:0]   pre_q, pre_d;
   logic [7:0]         cnt_q, cnt_d;
   logic [23:0]        pend_q, pend_d;
   logic [23:0]        act_q, act_d;
   logic               flag_q, flag_d;
   logic               pd_q;

   logic               running;
   logic               tick;
   logic               wrap;
   logic               load;

   assign running = (state_q != IDLE);
   assign tick    = running && (pre_q == PRE_MAX);
   assign wrap    = tick && (cnt_q == 8'hFF);

   // Re-enabling during DRAIN takes priority over the wrap so counting never breaks.
   always_comb begin
      // NOTE: every comb output gets a default first so no path can infer a latch.
      state_d = state_q;
      load    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (enable) begin
               state_d = RUN;
               load    = 1'b1;
            end
         end
         RUN: begin
            if (!enable) state_d = DRAIN;
         end
         DRAIN: begin
            if (enable)    state_d = RUN;
            else if (wrap) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (wrap) load = 1'b1;
   end

   always_comb begin
      pre_d = pre_q;
      cnt_d = cnt_q;
      if (!running) begin
         pre_d = '0;
         cnt_d = '0;
      end else if (tick) begin
         pre_d = '0;
         cnt_d = cnt_q + 8'd1;
      end else begin
         pre_d = pre_q + 1'b1;
      end
   end

   // A strobe coinciding with a load lands in pending after the old value moves out.
   always_comb begin
      pend_d = pend_q;
      act_d  = act_q;
      flag_d = flag_q;
      if (load && flag_q) begin
         act_d  = pend_q;
         flag_d = 1'b0;
      end
      if (rgb_valid) begin
         pend_d = rgb;
         flag_d = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         pre_q   <= '0;
         cnt_q   <= '0;
         pend_q  <= '0;
         act_q   <= '0;
         flag_q  <= 1'b0;
         pd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         act_q   <= act_d;
         flag_q  <= flag_d;
         pd_q    <= wrap;
      end
   end

   assign led_r          = running && (cnt_q < act_q[23:16]);
   assign led_g          = running && (cnt_q < act_q[15:8]);
   assign led_b          = running && (cnt_q < act_q[7:0]);
   assign period_done    = pd_q;
   assign update_pending = flag_q;

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Bench for rgb_pwm_driver: PRESCALE=1 and PRESCALE=4 instances, each cycle compared
// against a period-position reference model, plus directed duty/boundary scenarios.
module tb_rgb_pwm_driver;

   logic        clk = 1'b0;
   logic        rst;
   logic        en [2];
   logic        v  [2];
   logic [23:0] d  [2];
   logic        lr [2];
   logic        lg [2];
   logic        lb [2];
   logic        pd [2];
   logic        up [2];

   logic        s_rst;
   logic        s_en [2];
   logic        s_v  [2];
   logic [23:0] s_d  [2];

   int          checks   = 0;
   int          failures = 0;
   int          meas [2][4];

   // reference model: position within the period plus on/draining flags
   int          ps [2] = '{1, 4};
   bit          m_on    [2];
   bit          m_drain [2];
   int          m_pos   [2];
   logic [23:0] m_act   [2];
   logic [23:0] m_pend  [2];
   bit          m_flag  [2];
   bit          m_pd    [2];

   always #5 clk = ~clk;

   rgb_pwm_driver #(.PRESCALE(1)) u_p1 (
      .clk(clk), .rst(rst), .enable(en[0]), .rgb(d[0]), .rgb_valid(v[0]),
      .led_r(lr[0]), .led_g(lg[0]), .led_b(lb[0]),
      .period_done(pd[0]), .update_pending(up[0])
   );

   rgb_pwm_driver #(.PRESCALE(4)) u_p4 (
      .clk(clk), .rst(rst), .enable(en[1]), .rgb(d[1]), .rgb_valid(v[1]),
      .led_r(lr[1]), .led_g(lg[1]), .led_b(lb[1]),
      .period_done(pd[1]), .update_pending(up[1])
   );

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic bit exp_led(int k, int ch);
      int step = m_pos[k] / ps[k];
      int duty = int'(m_act[k][8*ch +: 8]);
      return m_on[k] && (step < duty);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_on[k] = 0; m_drain[k] = 0; m_pos[k] = 0;
         m_act[k] = '0; m_pend[k] = '0; m_flag[k] = 0; m_pd[k] = 0;
      end
   endtask

   task automatic model_step(int k);
      int per  = 256 * ps[k];
      bit wrap = m_on[k] && (m_pos[k] == per - 1);
      bit load = wrap || (!m_on[k] && en[k]);
      m_pd[k] = wrap;
      if (load && m_flag[k]) begin
         m_act[k]  = m_pend[k];
         m_flag[k] = 0;
      end
      if (v[k]) begin
         m_pend[k] = d[k];
         m_flag[k] = 1;
      end
      if (!m_on[k]) begin
         if (en[k]) begin
            m_on[k]    = 1;
            m_drain[k] = 0;
         end
         m_pos[k] = 0;
      end else begin
         m_pos[k] = (m_pos[k] + 1) % per;
         if (!m_drain[k]) begin
            if (!en[k]) m_drain[k] = 1;
         end else if (en[k]) begin
            m_drain[k] = 0;
         end else if (wrap) begin
            m_on[k]  = 0;
            m_pos[k] = 0;
         end
      end
   endtask

   // One clock: compare both instances at the negedge, apply staged inputs, advance model.
   task automatic cyc();
      logic [4:0] g, e;
      string      nm [5] = '{"update_pending", "period_done", "led_b", "led_g", "led_r"};
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         g = {lr[k], lg[k], lb[k], pd[k], up[k]};
         e = {exp_led(k, 2), exp_led(k, 1), exp_led(k, 0), m_pd[k], m_flag[k]};
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (g[i] !== e[i]) begin
               failures++;
               if (failures <= 30)
                  $display("FAIL cycle_%s inst%0d t=%0t got=%b exp=%b pos=%0d",
                           nm[i], k, $time, g[i], e[i], m_pos[k]);
            end
         end
         meas[k][0] += int'(lr[k]);
         meas[k][1] += int'(lg[k]);
         meas[k][2] += int'(lb[k]);
         meas[k][3] += int'(pd[k]);
      end
      rst = s_rst;
      for (int k = 0; k < 2; k++) begin
         en[k]  = s_en[k];
         v[k]   = s_v[k];
         d[k]   = s_d[k];
         s_v[k] = 1'b0;
      end
      if (rst) model_reset();
      else for (int k = 0; k < 2; k++) model_step(k);
   endtask

   task automatic wait_pos(int k, int p);
      int n = 0;
      checks++;
      while (m_pos[k] != p) begin
         cyc();
         n++;
         if (n > 5000) begin
            failures++;
            $display("FAIL wait_pos inst%0d got_pos=%0d exp_pos=%0d", k, m_pos[k], p);
            break;
         end
      end
   endtask

   task automatic measure(int n);
      for (int k = 0; k < 2; k++) meas[k] = '{0, 0, 0, 0};
      repeat (n) cyc();
   endtask

   task automatic test_reset();
      rst = 1'b1; s_rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         en[k] = 0; v[k] = 0; d[k] = '0; s_en[k] = 0; s_v[k] = 0; s_d[k] = '0;
      end
      model_reset();
      #1;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if ({lr[k], lg[k], lb[k], pd[k], up[k]} !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs inst%0d got=%b exp=00000", k,
                     {lr[k], lg[k], lb[k], pd[k], up[k]});
         end
      end
      repeat (3) cyc();
      s_rst = 1'b0;
      repeat (4) cyc();
   endtask

   task automatic test_basic();
      int ex1 [4] = '{255, 128, 0, 0};
      int ex2 [4] = '{255, 128, 0, 1};
      s_d[0] = 24'hFF8000; s_v[0] = 1'b1;
      cyc();
      s_en[0] = 1'b1;
      cyc();
      measure(256);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (meas[0][i] !== ex1[i]) begin
            failures++;
            $display("FAIL basic_first_period field%0d got=%0d exp=%0d", i, meas[0][i], ex1[i]);
         end
      end
      measure(256);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (meas[0][i] !== ex2[i]) begin
            failures++;
            $display("FAIL basic_second_period field%0d got=%0d exp=%0d", i, meas[0][i], ex2[i]);
         end
      end
   endtask

   task automatic test_update();
      int ex1 [4] = '{255, 128, 0, 1};
      int ex2 [4] = '{0, 0, 64, 1};
      wait_pos(0, 0);
      for (int k = 0; k < 2; k++) meas[k] = '{0, 0, 0, 0};
      wait_pos(0, 100);
      s_d[0] = 24'h000040; s_v[0] = 1'b1;
      cyc();
      cyc();
      checks++;
      if (up[0] !== 1'b1) begin
         failures++;
         $display("FAIL update_pending_set got=%b exp=1", up[0]);
      end
      wait_pos(0, 0);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (meas[0][i] !== ex1[i]) begin
            failures++;
            $display("FAIL update_current_period field%0d got=%0d exp=%0d", i, meas[0][i], ex1[i]);
         end
      end
      measure(256);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (meas[0][i] !== ex2[i]) begin
            failures++;
            $display("FAIL update_next_period field%0d got=%0d exp=%0d", i, meas[0][i], ex2[i]);
         end
      end
      checks++;
      if (up[0] !== 1'b0) begin
         failures++;
         $display("FAIL update_pending_clear got=%b exp=0", up[0]);
      end
   endtask

   task automatic test_last_wins();
      int ex [4] = '{32, 0, 0, 1};
      wait_pos(0, 10);
      s_d[0] = 24'h100000; s_v[0] = 1'b1;
      cyc();
      wait_pos(0, 20);
      s_d[0] = 24'h200000; s_v[0] = 1'b1;
      cyc();
      wait_pos(0, 0);
      measure(256);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (meas[0][i] !== ex[i]) begin
            failures++;
            $display("FAIL last_wins field%0d got=%0d exp=%0d", i, meas[0][i], ex[i]);
         end
      end
   endtask

   task automatic test_drain();
      wait_pos(0, 50);
      s_en[0] = 1'b0;
      cyc();
      wait_pos(0, 0);
      measure(300);
      checks++;
      if (meas[0][3] !== 1 || meas[0][0] !== 0) begin
         failures++;
         $display("FAIL drain_to_idle got_pd=%0d got_r=%0d exp_pd=1 exp_r=0",
                  meas[0][3], meas[0][0]);
      end
      s_en[0] = 1'b1;
      cyc();
      wait_pos(0, 50);
      s_en[0] = 1'b0;
      cyc();
      wait_pos(0, 200);
      s_en[0] = 1'b1;
      cyc();
      wait_pos(0, 0);
      measure(256);
      checks++;
      if (meas[0][0] !== 32 || meas[0][3] !== 1) begin
         failures++;
         $display("FAIL drain_resume got_r=%0d got_pd=%0d exp_r=32 exp_pd=1",
                  meas[0][0], meas[0][3]);
      end
   endtask

   task automatic test_prescale4();
      int ex1 [4] = '{4, 4, 4, 0};
      int ex2 [4] = '{4, 4, 4, 1};
      int ex3 [4] = '{8, 8, 8, 1};
      s_d[1] = 24'h010101; s_v[1] = 1'b1;
      cyc();
      s_en[1] = 1'b1;
      cyc();
      measure(1024);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (meas[1][i] !== ex1[i]) begin
            failures++;
            $display("FAIL ps4_duty1 field%0d got=%0d exp=%0d", i, meas[1][i], ex1[i]);
         end
      end
      wait_pos(1, 1023);
      s_d[1] = 24'h020202; s_v[1] = 1'b1;
      cyc();
      measure(1024);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (meas[1][i] !== ex2[i]) begin
            failures++;
            $display("FAIL ps4_wrap_strobe_same field%0d got=%0d exp=%0d", i, meas[1][i], ex2[i]);
         end
      end
      checks++;
      if (up[1] !== 1'b1) begin
         failures++;
         $display("FAIL ps4_pending_held got=%b exp=1", up[1]);
      end
      measure(1024);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (meas[1][i] !== ex3[i]) begin
            failures++;
            $display("FAIL ps4_duty2 field%0d got=%0d exp=%0d", i, meas[1][i], ex3[i]);
         end
      end
   endtask

   task automatic test_async_reset();
      s_d[0] = 24'h777777; s_v[0] = 1'b1;
      cyc();
      wait_pos(0, 5);
      @(posedge clk);
      #2;
      checks++;
      if (lr[0] !== 1'b1) begin
         failures++;
         $display("FAIL async_pre_led_r got=%b exp=1", lr[0]);
      end
      rst = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if ({lr[k], lg[k], lb[k], pd[k], up[k]} !== 5'b0) begin
            failures++;
            $display("FAIL async_reset_outputs inst%0d got=%b exp=00000", k,
                     {lr[k], lg[k], lb[k], pd[k], up[k]});
         end
      end
      model_reset();
      s_rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         s_en[k] = 1'b0; en[k] = 1'b0; s_v[k] = 1'b0; v[k] = 1'b0;
      end
      repeat (2) cyc();
      s_rst = 1'b0;
      measure(20);
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (meas[k][0] + meas[k][1] + meas[k][2] + meas[k][3] !== 0 || up[k] !== 1'b0) begin
            failures++;
            $display("FAIL async_post_idle inst%0d got_sum=%0d got_up=%b exp_sum=0 exp_up=0", k,
                     meas[k][0] + meas[k][1] + meas[k][2] + meas[k][3], up[k]);
         end
      end
   endtask

   function automatic logic [7:0] rand_chan();
      case ($urandom_range(0, 3))
         0:       return 8'h00;
         1:       return 8'hFF;
         default: return 8'($urandom);
      endcase
   endfunction

   task automatic test_random();
      for (int k = 0; k < 2; k++) s_en[k] = 1'b1;
      repeat (8000) begin
         for (int k = 0; k < 2; k++) begin
            if ($urandom_range(0, 299) == 0) s_en[k] = ~s_en[k];
            s_v[k] = ($urandom_range(0, 99) < 2);
            s_d[k] = {rand_chan(), rand_chan(), rand_chan()};
         end
         cyc();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_update();
      test_last_wins();
      test_drain();
      test_prescale4();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
